multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control FSM: decodes op/funct into datapath strobes, waits on mem_ready.
// Memory waits are bounded by TIMEOUT; a timeout or an undecodable instruction parks the FSM in ERROR until reset.
module multicycle_controller #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcen,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQ     = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_ERROR   = 4'd15
  } state_e;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       illegal_q, illegal_d;
  logic       waiting;
  logic       rfn_ok;
  logic [2:0] rfn_alu;

  always_comb begin
    rfn_ok  = 1'b1;
    rfn_alu = 3'b010;
    case (funct)
      6'b100000: rfn_alu = 3'b010;
      6'b100010: rfn_alu = 3'b110;
      6'b100100: rfn_alu = 3'b000;
      6'b100101: rfn_alu = 3'b001;
      6'b101010: rfn_alu = 3'b111;
      default:   rfn_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    iord       = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    pcen       = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = 3'b000;
    waiting    = 1'b0;
    case (state_q)
      S_FETCH: begin
        memread    = 1'b1;
        alusrcb    = 2'b01;
        alucontrol = 3'b010;
        irwrite    = mem_ready;
        pcen       = mem_ready;
        waiting    = 1'b1;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb    = 2'b11;
        alucontrol = 3'b010;
        case (op)
          6'b100011, 6'b101011: state_d = S_MEMADR;
          6'b000000:            state_d = rfn_ok ? S_RTYPEEX : S_ERROR;
          6'b000100:            state_d = S_BEQ;
          6'b001000:            state_d = S_ADDIEX;
          6'b000010:            state_d = S_JUMP;
          default:              state_d = S_ERROR;
        endcase
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = 3'b010;
        state_d    = (op == 6'b100011) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        memread = 1'b1;
        waiting = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        waiting  = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_RTYPEEX: begin
        alusrca    = 1'b1;
        alucontrol = rfn_alu;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQ: begin
        alusrca    = 1'b1;
        alucontrol = 3'b110;
        pcsrc      = 2'b01;
        pcen       = zero;
        state_d    = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = 3'b010;
        state_d    = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcen    = 1'b1;
        state_d = S_FETCH;
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase

    // This cycle is wait number wait_cnt_q+1; mem_ready on the last allowed cycle still wins.
    if (waiting && !mem_ready && (wait_cnt_q == TMO - 8'd1)) state_d = S_ERROR;
    wait_cnt_d = (waiting && !mem_ready) ? wait_cnt_q + 8'd1 : 8'd0;
    illegal_d  = illegal_q | (state_d == S_ERROR);

    if (reset) begin
      memread  = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      pcen     = 1'b0;
      regwrite = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= 8'd0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      illegal_q  <= illegal_d;
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle stimulus and expected outputs are queued,
// then each cycle's DUT outputs are compared at the falling edge.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       iord, memread, memwrite, irwrite, pcen, regwrite, regdst, memtoreg, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;
  logic       illegal;

  multicycle_controller #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .iord(iord), .memread(memread), .memwrite(memwrite), .irwrite(irwrite), .pcen(pcen),
    .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .state(state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Field order: state[20:17] iord memread memwrite irwrite pcen regwrite regdst memtoreg alusrca
  //              alusrcb[7:6] pcsrc[5:4] alucontrol[3:1] illegal[0]
  logic [20:0] got;
  assign got = {state, iord, memread, memwrite, irwrite, pcen, regwrite, regdst, memtoreg, alusrca,
                alusrcb, pcsrc, alucontrol, illegal};

  localparam logic [20:0] E_FETCH_R = {4'd0,  9'b010110000, 2'b01, 2'b00, 3'b010, 1'b0};
  localparam logic [20:0] E_FETCH_W = {4'd0,  9'b010000000, 2'b01, 2'b00, 3'b010, 1'b0};
  localparam logic [20:0] E_FETCH_X = {4'd0,  9'b000000000, 2'b01, 2'b00, 3'b010, 1'b0};
  localparam logic [20:0] E_DECODE  = {4'd1,  9'b000000000, 2'b11, 2'b00, 3'b010, 1'b0};
  localparam logic [20:0] E_MEMADR  = {4'd2,  9'b000000001, 2'b10, 2'b00, 3'b010, 1'b0};
  localparam logic [20:0] E_MEMRD   = {4'd3,  9'b110000000, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [20:0] E_MEMWB   = {4'd4,  9'b000001010, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [20:0] E_MEMWR   = {4'd5,  9'b101000000, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [20:0] E_MEMWR_X = {4'd5,  9'b100000000, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [20:0] E_ALUWB   = {4'd7,  9'b000001100, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [20:0] E_BEQ_T   = {4'd8,  9'b000010001, 2'b00, 2'b01, 3'b110, 1'b0};
  localparam logic [20:0] E_BEQ_N   = {4'd8,  9'b000000001, 2'b00, 2'b01, 3'b110, 1'b0};
  localparam logic [20:0] E_ADDIEX  = {4'd9,  9'b000000001, 2'b10, 2'b00, 3'b010, 1'b0};
  localparam logic [20:0] E_ADDIWB  = {4'd10, 9'b000001000, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [20:0] E_JUMP    = {4'd11, 9'b000010000, 2'b00, 2'b10, 3'b000, 1'b0};
  localparam logic [20:0] E_ERROR   = {4'd15, 9'b000000000, 2'b00, 2'b00, 3'b000, 1'b1};

  logic [14:0] stim_q[$];
  logic [20:0] exp_q[$];
  string       tag_q[$];
  logic [5:0]  cur_op = 6'd0;
  logic [5:0]  cur_funct = 6'd0;
  int          checks = 0;
  int          passed = 0;

  task automatic push(input logic r, input logic m, input logic z, input logic [20:0] e, input string t);
    stim_q.push_back({r, m, z, cur_op, cur_funct});
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  // Advance one cycle: drive the next queued inputs just after the rising edge, stop at the falling edge.
  task automatic step();
    logic [14:0] s;
    @(posedge clk);
    #1;
    s = stim_q.pop_front();
    {reset, mem_ready, zero, op, funct} = s;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [20:0] e;
    string t;
    push(1'b1, 1'b1, 1'b0, E_FETCH_X, "reset_hold");
    push(1'b0, 1'b0, 1'b0, E_FETCH_W, "reset_first_cycle");
    push(1'b1, 1'b0, 1'b0, E_FETCH_X, "reset_again");
    while (stim_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if (got !== e) $display("FAIL %s: got st=%0d ctl=%h, required st=%0d ctl=%h", t, got[20:17], got, e[20:17], e);
      else passed++;
    end
  endtask

  task automatic test_rtype();
    logic [20:0] e;
    string t;
    logic [5:0] fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] al [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    cur_op = 6'b000000;
    for (int i = 0; i < 5; i++) begin
      cur_funct = fn[i];
      push(1'b0, 1'b1, 1'b0, E_FETCH_R, "rtype_fetch");
      push(1'b0, 1'b1, 1'b0, E_DECODE, "rtype_decode");
      push(1'b0, 1'b1, 1'b0, {4'd6, 9'b000000001, 2'b00, 2'b00, al[i], 1'b0}, "rtype_ex");
      push(1'b0, 1'b1, 1'b0, E_ALUWB, "rtype_wb");
    end
    while (stim_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if (got !== e) $display("FAIL %s: got st=%0d ctl=%h, required st=%0d ctl=%h", t, got[20:17], got, e[20:17], e);
      else passed++;
    end
  endtask

  task automatic test_mem();
    logic [20:0] e;
    string t;
    cur_funct = 6'b000000;
    cur_op = 6'b100011;
    push(1'b0, 1'b1, 1'b0, E_FETCH_R, "lw_fetch");
    push(1'b0, 1'b1, 1'b0, E_DECODE, "lw_decode");
    push(1'b0, 1'b1, 1'b0, E_MEMADR, "lw_memadr");
    push(1'b0, 1'b0, 1'b0, E_MEMRD, "lw_memrd_wait1");
    push(1'b0, 1'b0, 1'b0, E_MEMRD, "lw_memrd_wait2");
    push(1'b0, 1'b1, 1'b0, E_MEMRD, "lw_memrd_done");
    push(1'b0, 1'b1, 1'b0, E_MEMWB, "lw_memwb");
    cur_op = 6'b101011;
    push(1'b0, 1'b0, 1'b0, E_FETCH_W, "sw_fetch_wait");
    push(1'b0, 1'b1, 1'b0, E_FETCH_R, "sw_fetch");
    push(1'b0, 1'b1, 1'b0, E_DECODE, "sw_decode");
    push(1'b0, 1'b1, 1'b0, E_MEMADR, "sw_memadr");
    push(1'b0, 1'b1, 1'b0, E_MEMWR, "sw_memwr");
    push(1'b0, 1'b1, 1'b0, E_FETCH_R, "sw_back_to_fetch");
    while (stim_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if (got !== e) $display("FAIL %s: got st=%0d ctl=%h, required st=%0d ctl=%h", t, got[20:17], got, e[20:17], e);
      else passed++;
    end
  endtask

  // Resumes in DECODE: test_mem left the FSM having just fetched.
  task automatic test_back_to_back();
    logic [20:0] e;
    string t;
    cur_op = 6'b001000;
    push(1'b0, 1'b1, 1'b0, E_DECODE, "addi_decode");
    push(1'b0, 1'b1, 1'b0, E_ADDIEX, "addi_ex");
    push(1'b0, 1'b1, 1'b0, E_ADDIWB, "addi_wb");
    cur_op = 6'b000010;
    push(1'b0, 1'b1, 1'b0, E_FETCH_R, "j_fetch");
    push(1'b0, 1'b1, 1'b0, E_DECODE, "j_decode");
    push(1'b0, 1'b1, 1'b0, E_JUMP, "j_jump");
    cur_op = 6'b000100;
    push(1'b0, 1'b1, 1'b0, E_FETCH_R, "beqt_fetch");
    push(1'b0, 1'b1, 1'b0, E_DECODE, "beqt_decode");
    push(1'b0, 1'b1, 1'b1, E_BEQ_T, "beq_taken");
    push(1'b0, 1'b1, 1'b1, E_FETCH_R, "beqn_fetch");
    push(1'b0, 1'b1, 1'b1, E_DECODE, "beqn_decode");
    push(1'b0, 1'b1, 1'b0, E_BEQ_N, "beq_not_taken");
    push(1'b0, 1'b0, 1'b0, E_FETCH_W, "beq_back_to_fetch");
    push(1'b1, 1'b0, 1'b0, E_FETCH_X, "b2b_reset");
    while (stim_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if (got !== e) $display("FAIL %s: got st=%0d ctl=%h, required st=%0d ctl=%h", t, got[20:17], got, e[20:17], e);
      else passed++;
    end
  endtask

  task automatic test_illegal();
    logic [20:0] e;
    string t;
    logic [11:0] bad [3] = '{{6'b111111, 6'b000000}, {6'b000000, 6'b000011}, {6'b000001, 6'b100000}};
    for (int i = 0; i < 3; i++) begin
      {cur_op, cur_funct} = bad[i];
      push(1'b0, 1'b1, 1'b0, E_FETCH_R, "illegal_fetch");
      push(1'b0, 1'b1, 1'b0, E_DECODE, "illegal_decode");
      for (int k = 0; k < 20; k++)
        push(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), E_ERROR, "illegal_hold");
      push(1'b1, 1'b1, 1'b0, E_ERROR, "illegal_in_reset");
      push(1'b0, 1'b0, 1'b0, E_FETCH_W, "illegal_cleared");
      push(1'b1, 1'b0, 1'b0, E_FETCH_X, "illegal_reset2");
    end
    while (stim_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if (got !== e) $display("FAIL %s: got st=%0d ctl=%h, required st=%0d ctl=%h", t, got[20:17], got, e[20:17], e);
      else passed++;
    end
  endtask

  task automatic test_timeout();
    logic [20:0] e;
    string t;
    cur_op = 6'b000010;
    cur_funct = 6'b000000;
    for (int k = 0; k < 15; k++) push(1'b0, 1'b0, 1'b0, E_FETCH_W, "timeout_wait");
    push(1'b0, 1'b0, 1'b0, E_ERROR, "timeout_error");
    push(1'b1, 1'b1, 1'b0, E_ERROR, "timeout_error_reset");
    for (int k = 0; k < 14; k++) push(1'b0, 1'b0, 1'b0, E_FETCH_W, "edge_wait");
    push(1'b0, 1'b1, 1'b0, E_FETCH_R, "edge_ready_wins");
    push(1'b0, 1'b1, 1'b0, E_DECODE, "edge_decode");
    push(1'b0, 1'b1, 1'b0, E_JUMP, "edge_jump");
    while (stim_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if (got !== e) $display("FAIL %s: got st=%0d ctl=%h, required st=%0d ctl=%h", t, got[20:17], got, e[20:17], e);
      else passed++;
    end
  endtask

  task automatic test_reset_midwait();
    logic [20:0] e;
    string t;
    cur_op = 6'b101011;
    push(1'b0, 1'b1, 1'b0, E_FETCH_R, "midwait_fetch");
    push(1'b0, 1'b1, 1'b0, E_DECODE, "midwait_decode");
    push(1'b0, 1'b1, 1'b0, E_MEMADR, "midwait_memadr");
    for (int k = 0; k < 3; k++) push(1'b0, 1'b0, 1'b0, E_MEMWR, "midwait_memwr_wait");
    push(1'b1, 1'b0, 1'b0, E_MEMWR_X, "midwait_memwr_in_reset");
    push(1'b0, 1'b0, 1'b0, E_FETCH_W, "midwait_after_reset");
    while (stim_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if (got !== e) $display("FAIL %s: got st=%0d ctl=%h, required st=%0d ctl=%h", t, got[20:17], got, e[20:17], e);
      else passed++;
    end
  endtask

  initial begin
    reset = 1'b1;
    op = 6'd0;
    funct = 6'd0;
    zero = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_rtype();
    test_mem();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_reset_midwait();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
